// File: rtl/bus_map_pkg.sv
// Shared address map for the 8-bit processor bus.
// Holds peripheral base addresses, timer register offsets and the common window decode.
package bus_map_pkg;

  localparam int BUS_DATA_W = 8;
  localparam int BUS_ADDR_W = 8;

  // Each peripheral owns an 8-byte window, so the low three address bits are the offset.
  localparam int WINDOW_OFS_W = 3;

  localparam logic [BUS_ADDR_W-1:0] MOUSE_BASE_ADDR = 8'hA0;
  localparam logic [BUS_ADDR_W-1:0] VGA_BASE_ADDR   = 8'hB0;
  localparam logic [BUS_ADDR_W-1:0] LED_BASE_ADDR   = 8'hC0;
  localparam logic [BUS_ADDR_W-1:0] SEG7_BASE_ADDR  = 8'hD0;
  localparam logic [BUS_ADDR_W-1:0] TIMER_BASE_ADDR = 8'hF0;

  localparam logic [WINDOW_OFS_W-1:0] TIMER_OFS_CNT0   = 3'd0;
  localparam logic [WINDOW_OFS_W-1:0] TIMER_OFS_CNT1   = 3'd1;
  localparam logic [WINDOW_OFS_W-1:0] TIMER_OFS_CNT2   = 3'd2;
  localparam logic [WINDOW_OFS_W-1:0] TIMER_OFS_CNT3   = 3'd3;
  localparam logic [WINDOW_OFS_W-1:0] TIMER_OFS_RATE   = 3'd4;
  localparam logic [WINDOW_OFS_W-1:0] TIMER_OFS_ENABLE = 3'd5;
  localparam logic [WINDOW_OFS_W-1:0] TIMER_OFS_CLEAR  = 3'd6;
  localparam logic [WINDOW_OFS_W-1:0] TIMER_OFS_RSVD   = 3'd7;

  typedef struct packed {
    logic                    rd;
    logic                    wr;
    logic [WINDOW_OFS_W-1:0] ofs;
  } bus_req_t;

  function automatic bus_req_t decode_req(
    input logic [BUS_ADDR_W-1:0] addr,
    input logic                  we,
    input logic [BUS_ADDR_W-1:0] base
  );
    bus_req_t req;
    logic     hit;
    hit     = (addr[BUS_ADDR_W-1:WINDOW_OFS_W] == base[BUS_ADDR_W-1:WINDOW_OFS_W]);
    req.rd  = hit & ~we;
    req.wr  = hit & we;
    req.ofs = addr[WINDOW_OFS_W-1:0];
    return req;
  endfunction

endpackage

// File: rtl/Generic_counter.sv
// Free-running modulo counter that pulses TRIG_OUT for one cycle as it wraps.
module Generic_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TRIG_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] MaxCount = COUNTER_WIDTH'(COUNTER_MAX);

  logic [COUNTER_WIDTH-1:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (ENABLE) begin
      if (count == MaxCount) begin
        count <= '0;
      end else begin
        count <= count + COUNTER_WIDTH'(1);
      end
    end
  end

  assign TRIG_OUT = ENABLE && (count == MaxCount);

endmodule

// File: rtl/timer_bus_peripheral.sv
// Memory-mapped millisecond timer: readable ms counter, configurable periodic
// interrupt with raise/acknowledge handshake, answers reads one cycle late.
module timer_bus_peripheral
  import bus_map_pkg::*;
#(
  parameter logic [7:0] TimerBaseAddr  = TIMER_BASE_ADDR,
  parameter int         ClksPerMs      = 100000,
  parameter logic [7:0] DefaultIrqRate = 8'd100
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [0:0] IRQ_IDLE    = 1'b0;
  localparam logic [0:0] IRQ_PENDING = 1'b1;

  bus_req_t    req;
  logic        wr_rate;
  logic        wr_enable;
  logic        wr_clear;
  logic        prescale_clear;
  logic        ms_tick;
  logic [31:0] ms_count;
  logic [23:0] snap_hi;
  logic [7:0]  irq_rate;
  logic        irq_enable;
  logic [7:0]  irq_timer;
  logic        irq_event;
  logic [0:0]  irq_state;
  logic [7:0]  read_mux;
  logic [7:0]  rd_data;
  logic        drive_en;

  assign req       = decode_req(BUS_ADDR, BUS_WE, TimerBaseAddr);
  assign wr_rate   = req.wr && (req.ofs == TIMER_OFS_RATE);
  assign wr_enable = req.wr && (req.ofs == TIMER_OFS_ENABLE);
  assign wr_clear  = req.wr && (req.ofs == TIMER_OFS_CLEAR);

  assign prescale_clear = RESET || wr_clear;

  Generic_counter #(
    .COUNTER_WIDTH(17),
    .COUNTER_MAX  (ClksPerMs - 1)
  ) u_prescaler (
    .CLK     (CLK),
    .RESET   (prescale_clear),
    .ENABLE  (1'b1),
    .TRIG_OUT(ms_tick)
  );

  always_ff @(posedge CLK) begin
    if (RESET || wr_clear) begin
      ms_count <= '0;
    end else if (ms_tick) begin
      ms_count <= ms_count + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_rate   <= DefaultIrqRate;
      irq_enable <= 1'b0;
    end else begin
      if (wr_rate) begin
        irq_rate <= BUS_DATA;
      end
      if (wr_enable) begin
        irq_enable <= BUS_DATA[0];
      end
    end
  end

  // A clear or a new period restarts the interval and swallows any coincident event.
  assign irq_event = ms_tick && (irq_rate != 8'd0) && (irq_timer == irq_rate - 8'd1)
                     && !wr_rate && !wr_clear;

  always_ff @(posedge CLK) begin
    if (RESET || wr_clear || wr_rate || (irq_rate == 8'd0)) begin
      irq_timer <= '0;
    end else if (ms_tick) begin
      if (irq_timer == irq_rate - 8'd1) begin
        irq_timer <= '0;
      end else begin
        irq_timer <= irq_timer + 8'd1;
      end
    end
  end

  // Only ACK retires a pending request; an event on the same edge keeps it raised.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_state <= IRQ_IDLE;
    end else if (irq_event && irq_enable) begin
      irq_state <= IRQ_PENDING;
    end else if (BUS_INTERRUPT_ACK) begin
      irq_state <= IRQ_IDLE;
    end
  end

  assign BUS_INTERRUPT_RAISE = (irq_state == IRQ_PENDING);

  always_comb begin
    read_mux = 8'd0;
    case (req.ofs)
      TIMER_OFS_CNT0:   read_mux = ms_count[7:0];
      TIMER_OFS_CNT1:   read_mux = snap_hi[7:0];
      TIMER_OFS_CNT2:   read_mux = snap_hi[15:8];
      TIMER_OFS_CNT3:   read_mux = snap_hi[23:16];
      TIMER_OFS_RATE:   read_mux = irq_rate;
      TIMER_OFS_ENABLE: read_mux = {7'b0, irq_enable};
      default:          read_mux = 8'd0;
    endcase
  end

  // Reading the low byte freezes the upper bytes so a multi-byte read is coherent.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      snap_hi <= '0;
    end else if (req.rd && (req.ofs == TIMER_OFS_CNT0)) begin
      snap_hi <= ms_count[31:8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      drive_en <= 1'b0;
      rd_data  <= '0;
    end else begin
      drive_en <= req.rd;
      if (req.rd) begin
        rd_data <= read_mux;
      end
    end
  end

  assign BUS_DATA = drive_en ? rd_data : 8'bz;

endmodule

// File: tb/tb_timer_bus_peripheral.sv
// Self-checking bench: directed scenarios plus random bus traffic, compared every
// cycle against a tick-arithmetic model of the timer.
module tb_timer_bus_peripheral;

  localparam int CLKS = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bus_addr = 8'h10;
  logic       bus_we = 1'b0;
  logic       bus_ack = 1'b0;
  logic       raise;
  wire  [7:0] bus_data;

  logic       tb_drive = 1'b1;
  logic [7:0] tb_val = 8'h5A;
  bit         check_on = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] m_ms = '0;
  logic [23:0] m_snap = '0;
  logic [7:0]  m_rate = 8'd100;
  logic [7:0]  m_data = '0;
  logic        m_en = 1'b0;
  logic        m_raise = 1'b0;
  logic        m_drive = 1'b0;
  int          m_edges = 0;
  int          m_irq_ms = 0;

  // The bench plays the processor: it owns the bus whenever the timer should be silent,
  // so a stray timer drive corrupts the probe value it reads back.
  assign bus_data = tb_drive ? tb_val : 8'bz;

  always #5 clk = ~clk;

  timer_bus_peripheral #(
    .ClksPerMs(CLKS)
  ) dut (
    .CLK                (clk),
    .RESET              (reset),
    .BUS_DATA           (bus_data),
    .BUS_ADDR           (bus_addr),
    .BUS_WE             (bus_we),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK  (bus_ack)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ms ticks come from counting edges since the last reset/clear, and an
  // interrupt is due whenever the tick count since the last period change hits a multiple.
  task automatic model_step();
    logic       hit, rd, wr, tick, event_now;
    logic [2:0] ofs;
    logic [7:0] rdata;
    if (reset) begin
      m_ms = '0; m_snap = '0; m_rate = 8'd100; m_en = 1'b0;
      m_raise = 1'b0; m_drive = 1'b0; m_edges = 0; m_irq_ms = 0;
      return;
    end
    hit  = (bus_addr >= 8'hF0) && (bus_addr <= 8'hF7);
    ofs  = 3'(bus_addr - 8'hF0);
    wr   = hit && bus_we;
    rd   = hit && !bus_we;
    tick = (m_edges % CLKS) == (CLKS - 1);
    event_now = tick && (m_rate != 0) && (((m_irq_ms + 1) % int'(m_rate)) == 0)
                && !(wr && (ofs == 3'd4 || ofs == 3'd6));
    case (ofs)
      3'd0:    rdata = m_ms[7:0];
      3'd1:    rdata = m_snap[7:0];
      3'd2:    rdata = m_snap[15:8];
      3'd3:    rdata = m_snap[23:16];
      3'd4:    rdata = m_rate;
      3'd5:    rdata = {7'b0, m_en};
      default: rdata = 8'd0;
    endcase
    if (rd) begin
      m_drive = 1'b1;
      m_data  = rdata;
      if (ofs == 3'd0) m_snap = m_ms[31:8];
    end else begin
      m_drive = 1'b0;
    end
    if (event_now && m_en) m_raise = 1'b1;
    else if (bus_ack) m_raise = 1'b0;
    if (wr && ofs == 3'd6) begin
      m_ms = '0; m_edges = 0; m_irq_ms = 0;
    end else begin
      m_edges++;
      if (tick) begin
        m_ms = m_ms + 32'd1;
        if (m_rate != 0) m_irq_ms++;
      end
    end
    if (wr && ofs == 3'd4) begin
      m_rate = tb_val; m_irq_ms = 0;
    end
    if (wr && ofs == 3'd5) m_en = tb_val[0];
  endtask

  task automatic apply_stimulus(input logic [7:0] addr, input logic we, input logic [7:0] wdata,
                                input logic ack, input logic rst);
    bus_addr = addr;
    bus_we   = we;
    bus_ack  = ack;
    reset    = rst;
    if (we) tb_val = wdata;
    @(posedge clk);
    model_step();
    #1;
    tb_drive = !m_drive;
    tb_val   = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_raise(input string name, input int limit);
    int k = 0;
    while (!raise && k < limit) begin
      idle(1);
      k++;
    end
    check_output(name, {31'b0, raise}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      check_output("raise", {31'b0, raise}, {31'b0, m_raise});
      check_output("bus_data", {24'b0, bus_data}, {24'b0, (m_drive ? m_data : tb_val)});
    end
  end

  initial begin
    logic [7:0] addr;
    logic       we, ack, rst;
    logic [7:0] wdata;

    $display("[TB] start");
    apply_stimulus(8'h10, 1'b0, 8'h00, 1'b0, 1'b1);
    check_on = 1'b1;
    apply_stimulus(8'h10, 1'b0, 8'h00, 1'b0, 1'b1);

    apply_stimulus(8'hF4, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_output("read_rate_default", {24'b0, bus_data}, 32'd100);
    apply_stimulus(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_output("e0_highz", {24'b0, bus_data}, {24'b0, tb_val});
    idle(298);
    apply_stimulus(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_output("cnt0_after_300", {24'b0, bus_data}, 32'd30);
    apply_stimulus(8'hF1, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_output("cnt1_after_300", {24'b0, bus_data}, 32'd0);
    idle(1);
    apply_stimulus(8'hF6, 1'b1, 8'hA5, 1'b0, 1'b0);
    apply_stimulus(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_output("cnt0_after_clear", {24'b0, bus_data}, 32'd0);
    idle(1);

    // Periodic interrupt with a 3 ms period, prescaler phase pinned by a clear.
    apply_stimulus(8'hF6, 1'b1, 8'h00, 1'b0, 1'b0);
    apply_stimulus(8'hF4, 1'b1, 8'd3, 1'b0, 1'b0);
    apply_stimulus(8'hF5, 1'b1, 8'd1, 1'b0, 1'b0);
    idle(27);
    #1 check_output("raise_before_event", {31'b0, raise}, 32'd0);
    idle(1);
    #1 check_output("raise_on_event", {31'b0, raise}, 32'd1);
    idle(100);
    #1 check_output("raise_held_no_ack", {31'b0, raise}, 32'd1);
    apply_stimulus(8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    #1 check_output("raise_dropped_by_ack", {31'b0, raise}, 32'd0);
    idle(18);
    #1 check_output("raise_low_until_next", {31'b0, raise}, 32'd0);
    idle(1);
    #1 check_output("raise_next_event", {31'b0, raise}, 32'd1);
    idle(29);
    apply_stimulus(8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    #1 check_output("event_beats_ack", {31'b0, raise}, 32'd1);
    apply_stimulus(8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    #1 check_output("second_ack_clears", {31'b0, raise}, 32'd0);

    apply_stimulus(8'hF4, 1'b1, 8'd0, 1'b0, 1'b0);
    idle(10000);
    #1 check_output("rate_zero_no_raise", {31'b0, raise}, 32'd0);
    apply_stimulus(8'hF4, 1'b1, 8'd3, 1'b0, 1'b0);
    wait_raise("raise_wait_rate3", 60);
    apply_stimulus(8'hF5, 1'b1, 8'd0, 1'b0, 1'b0);
    idle(50);
    #1 check_output("raise_kept_when_disabled", {31'b0, raise}, 32'd1);
    apply_stimulus(8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(40);
    #1 check_output("disabled_events_dropped", {31'b0, raise}, 32'd0);

    // Counter wrap: preload all-ones, snapshot it, then let one tick roll it to zero.
    apply_stimulus(8'hF6, 1'b1, 8'h00, 1'b0, 1'b0);
    force dut.ms_count = 32'hFFFF_FFFF;
    #1 release dut.ms_count;
    m_ms = 32'hFFFF_FFFF;
    apply_stimulus(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_output("cnt0_preload", {24'b0, bus_data}, 32'hFF);
    apply_stimulus(8'hF3, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_output("cnt3_preload", {24'b0, bus_data}, 32'hFF);
    idle(8);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'hF0 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b0);
      #1 check_output($sformatf("cnt%0d_after_wrap", i), {24'b0, bus_data}, 32'd0);
    end
    idle(1);

    // Reset while a read answer and an interrupt are both pending.
    apply_stimulus(8'hF4, 1'b1, 8'd1, 1'b0, 1'b0);
    apply_stimulus(8'hF5, 1'b1, 8'd1, 1'b0, 1'b0);
    wait_raise("raise_wait_rate1", 30);
    apply_stimulus(8'hF4, 1'b0, 8'h00, 1'b0, 1'b0);
    apply_stimulus(8'h10, 1'b0, 8'h00, 1'b0, 1'b1);
    #1 check_output("reset_aborts_read", {24'b0, bus_data}, {24'b0, tb_val});
    check_output("reset_drops_raise", {31'b0, raise}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      addr = ($urandom_range(0, 9) < 8) ? {5'h1E, 3'($urandom_range(0, 7))} : 8'($urandom);
      we   = !m_drive && ($urandom_range(0, 3) == 0);
      if (we && addr == 8'hF6 && $urandom_range(0, 3) != 0) we = 1'b0;
      wdata = (addr == 8'hF4) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      ack  = ($urandom_range(0, 7) == 0);
      apply_stimulus(addr, we, wdata, ack, rst);
    end

    idle(2);
    check_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
